serial_borrow_subtractor: RTL and testbench
===========================================

# serial_borrow_subtractor

Multi-precision subtractor, dual of the team's 8-bit prefix adder: computes D = A − B − BIN over WIDTH bits, one 8-bit slice per clock, LSB slice first. Each slice uses 8-bit Brent-Kung prefix carry logic on A + ~B + ~borrow; the borrow is registered between slices. It sits between a valid/ready operand source and a valid/ready result sink and accepts one operation at a time, with no overlap.

## Interface
- WIDTH, 32, operand/result width; multiple of 8, ≥ 8; N = WIDTH/8 slices
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operand source has a request
- in_ready  output  1  block is idle and can accept a request
- a  input  WIDTH  minuend, sampled at accept
- b  input  WIDTH  subtrahend, sampled at accept
- bin  input  1  borrow-in, sampled at accept
- out_valid  output  1  result registers hold a completed result
- out_ready  input  1  sink accepts the result
- d  output  WIDTH  difference, modulo 2^WIDTH
- bout  output  1  borrow-out; 1 iff unsigned a < b + bin
- ovf  output  1  signed overflow
- zero  output  1  d == 0

## Operation
- States: IDLE, RUN, DONE. Reset (async, rst_n=0) → IDLE. Outputs during and after reset: in_ready=1, out_valid=0, d=0, bout=0, ovf=0, zero=0. Slice index and borrow register are cleared.
- IDLE: in_ready=1. On accept (in_valid & in_ready at an edge):
  - latch a, b, and ~b into operand registers
  - borrow register ← bin
  - index ← 0
  - → RUN
- RUN: in_ready=0. Each edge:
  - slice k = index computes {c8, s} = a[8k+7:8k] + ~b[8k+7:8k] + ~borrow (prefix adder, carry-in = ~borrow)
  - d[8k+7:8k] ← s; borrow ← ~c8; index ← index+1
  - The edge that processes k = N−1 moves → DONE and registers bout = ~c8, ovf = (a[MSB]≠b[MSB]) & (d[MSB]≠a[MSB]), zero = (all slices == 0).
- DONE: out_valid=1. d, bout, ovf and zero are held stable until out_ready=1 at an edge, then → IDLE.
- Result outputs keep their last values in IDLE. Only out_valid qualifies them.
- Input changes outside the accept edge have no effect.
- rst_n asserted in any state aborts the operation at once. The partial result is discarded and all outputs return to their reset values.
- bin=1 with a == b gives d = all ones, bout=1, zero=0.

## Timing
- Accept at edge T. Slices 0..N−1 are processed at edges T+1..T+N. out_valid is high from just after edge T+N. Latency is N cycles (4 for WIDTH=32).
- out_valid stays high until the handshake edge H (out_valid & out_ready). in_ready=1 from just after H. The earliest next accept is edge H+1.
- Throughput: one operation per N+2 cycles when the sink holds out_ready=1 and the source holds in_valid=1.
- in_ready and out_valid are never both 1.
- The critical path is one 8-bit prefix carry chain plus the borrow register, not WIDTH bits.

## Test plan
- Basic: a=0x00000005, b=0x00000003, bin=0 → d=0x00000002, bout=0, ovf=0, zero=0; out_valid rises exactly 4 cycles after the accept edge.
- Full borrow ripple: a=0x00010000, b=0x00000001 → d=0x0000FFFF, bout=0. Also a=0x00000000, b=0x00000001 → d=0xFFFFFFFF, bout=1, ovf=0.
- Signed overflow and borrow-in: a=0x80000000, b=0x00000001, bin=0 → d=0x7FFFFFFF, ovf=1, bout=0. Also a=b=0x00000005, bin=1 → d=0xFFFFFFFF, bout=1, zero=0.
- Zero flag: a=b=0x12345678, bin=0 → d=0x00000000, zero=1, bout=0, ovf=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid rises → d and flags are stable, in_ready=0, and new in_valid/a/b are ignored; release out_ready → in_ready=1 the next cycle; a back-to-back second op completes correctly.
- Reset mid-operation: assert rst_n=0 during RUN (after slice 1) → out_valid=0, in_ready=1, d=0 immediately (async); release reset → a fresh operation (0x0000FFFF − 0x0000FFFE → 0x00000001) completes normally.

Source files
------------

// File: rtl/serial_borrow_subtractor.sv
// Multi-precision subtractor: D = A - B - BIN, one 8-bit Brent-Kung slice per clock,
// LSB slice first, with the borrow carried between slices in a register.
module serial_borrow_subtractor #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned N    = WIDTH / 8;
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] nb_q;
    logic             b_msb_q;
    logic             borrow_q;
    logic [IdxW-1:0]  idx_q;
    logic             nz_q;
    logic [WIDTH-1:0] d_q;
    logic             bout_q;
    logic             ovf_q;
    logic             zero_q;

    logic [7:0] x, y, g, p, gpre, ppre, sum;
    logic [8:0] c;
    logic       cin;

    assign x   = a_q[{idx_q, 3'b000} +: 8];
    assign y   = nb_q[{idx_q, 3'b000} +: 8];
    assign cin = ~borrow_q;
    assign g   = x & y;
    assign p   = x ^ y;

    // Brent-Kung prefix tree: up-sweep pairs/quads/octet, then down-sweep fill-in.
    logic g10, p10, g32, p32, g54, p54, g76, p76;
    logic g30, p30, g74, p74;
    always_comb begin
        g10 = g[1] | (p[1] & g[0]);   p10 = p[1] & p[0];
        g32 = g[3] | (p[3] & g[2]);   p32 = p[3] & p[2];
        g54 = g[5] | (p[5] & g[4]);   p54 = p[5] & p[4];
        g76 = g[7] | (p[7] & g[6]);   p76 = p[7] & p[6];
        g30 = g32 | (p32 & g10);      p30 = p32 & p10;
        g74 = g76 | (p76 & g54);      p74 = p76 & p54;

        gpre[0] = g[0];                    ppre[0] = p[0];
        gpre[1] = g10;                     ppre[1] = p10;
        gpre[2] = g[2] | (p[2] & g10);     ppre[2] = p[2] & p10;
        gpre[3] = g30;                     ppre[3] = p30;
        gpre[4] = g[4] | (p[4] & g30);     ppre[4] = p[4] & p30;
        gpre[5] = g54 | (p54 & g30);       ppre[5] = p54 & p30;
        gpre[6] = g[6] | (p[6] & gpre[5]); ppre[6] = p[6] & ppre[5];
        gpre[7] = g74 | (p74 & g30);       ppre[7] = p74 & p30;

        c[0] = cin;
        for (int i = 0; i < 8; i++) begin
            c[i+1] = gpre[i] | (ppre[i] & cin);
        end
        sum = p ^ c[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_q      <= '0;
            nb_q     <= '0;
            b_msb_q  <= 1'b0;
            borrow_q <= 1'b0;
            idx_q    <= '0;
            nz_q     <= 1'b0;
            d_q      <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q      <= a;
                        nb_q     <= ~b;
                        b_msb_q  <= b[WIDTH-1];
                        borrow_q <= bin;
                        idx_q    <= '0;
                        nz_q     <= 1'b0;
                        state_q  <= StRun;
                    end
                end
                StRun: begin
                    d_q[{idx_q, 3'b000} +: 8] <= sum;
                    borrow_q <= ~c[8];
                    idx_q    <= idx_q + 1'b1;
                    nz_q     <= nz_q | (|sum);
                    if (idx_q == LastIdx) begin
                        state_q <= StDone;
                        bout_q  <= ~c[8];
                        ovf_q   <= (a_q[WIDTH-1] ^ b_msb_q) & (sum[7] ^ a_q[WIDTH-1]);
                        zero_q  <= ~nz_q & ~(|sum);
                    end
                end
                StDone: begin
                    if (out_ready) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign d         = d_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_serial_borrow_subtractor.sv
// Directed bench for serial_borrow_subtractor: hand-computed vectors, latency,
// backpressure and asynchronous reset mid-operation.
module tb_serial_borrow_subtractor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        bin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] d;
    logic        bout, ovf, zero;

    int total = 0;
    int bad   = 0;
    int lat;

    serial_borrow_subtractor #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .bin      (bin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .d        (d),
        .bout     (bout),
        .ovf      (ovf),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accept one operation and wait (bounded) for out_valid; returns cycles since accept.
    task automatic start_op(input logic [31:0] av, input logic [31:0] bv, input logic bi,
                            output int cycles);
        @(negedge clk);
        check("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
        a = av; b = bv; bin = bi; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        a = 32'hDEAD_BEEF; b = 32'h1234_5678; bin = ~bi;
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            @(posedge clk);
            #1 cycles++;
        end
    endtask

    task automatic check_result(input string tag, input logic [31:0] ed, input logic eb,
                                input logic eo, input logic ez);
        check({tag, "_d"},    d, ed);
        check({tag, "_bout"}, {31'b0, bout}, {31'b0, eb});
        check({tag, "_ovf"},  {31'b0, ovf},  {31'b0, eo});
        check({tag, "_zero"}, {31'b0, zero}, {31'b0, ez});
    endtask

    task automatic finish_op(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check({tag, "_in_ready_after"},  {31'b0, in_ready},  32'd1);
        check({tag, "_out_valid_after"}, {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_in_ready",  {31'b0, in_ready},  32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_d",         d, 32'd0);
        check("rst_flags",     {29'b0, bout, ovf, zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic, with exact latency
        start_op(32'h0000_0005, 32'h0000_0003, 1'b0, lat);
        check("basic_latency", lat, 32'd4);
        check("basic_in_ready_low", {31'b0, in_ready}, 32'd0);
        check_result("basic", 32'h0000_0002, 1'b0, 1'b0, 1'b0);
        finish_op("basic");

        // Borrow ripple across slices
        start_op(32'h0001_0000, 32'h0000_0001, 1'b0, lat);
        check("ripple1_latency", lat, 32'd4);
        check_result("ripple1", 32'h0000_FFFF, 1'b0, 1'b0, 1'b0);
        finish_op("ripple1");

        start_op(32'h0000_0000, 32'h0000_0001, 1'b0, lat);
        check_result("ripple2", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        finish_op("ripple2");

        // Signed overflow
        start_op(32'h8000_0000, 32'h0000_0001, 1'b0, lat);
        check_result("ovf", 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
        finish_op("ovf");

        // Borrow-in with equal operands
        start_op(32'h0000_0005, 32'h0000_0005, 1'b1, lat);
        check_result("bin_eq", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        finish_op("bin_eq");

        // Zero flag
        start_op(32'h1234_5678, 32'h1234_5678, 1'b0, lat);
        check_result("zero", 32'h0000_0000, 1'b0, 1'b0, 1'b1);
        finish_op("zero");

        // Backpressure: result held while the source keeps offering new work
        start_op(32'h0000_1000, 32'h0000_0001, 1'b0, lat);
        @(negedge clk);
        in_valid = 1'b1; a = 32'h5555_5555; b = 32'h1111_1111; bin = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_out_valid", {31'b0, out_valid}, 32'd1);
            check("bp_in_ready",  {31'b0, in_ready},  32'd0);
            check("bp_d",         d, 32'h0000_0FFF);
            check("bp_flags",     {29'b0, bout, ovf, zero}, 32'd0);
        end
        in_valid = 1'b0;
        finish_op("bp");
        // Back-to-back second op
        start_op(32'h0000_0064, 32'h0000_00C8, 1'b0, lat);
        check("b2b_latency", lat, 32'd4);
        check_result("b2b", 32'hFFFF_FF9C, 1'b1, 1'b0, 1'b0);
        finish_op("b2b");

        // Reset mid-operation, after slices 0 and 1
        @(negedge clk);
        a = 32'hFFFF_FFFF; b = 32'h0000_0001; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_in_ready",  {31'b0, in_ready},  32'd1);
        check("mid_rst_d",         d, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start_op(32'h0000_FFFF, 32'h0000_FFFE, 1'b0, lat);
        check("post_rst_latency", lat, 32'd4);
        check_result("post_rst", 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        finish_op("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
